// File: rtl/ysyx_22041752_mem_arbiter_pkg.sv
// rtl/ysyx_22041752_mem_arbiter_pkg.sv - shared widths and owner encoding for the memory arbiter
package ysyx_22041752_mem_arbiter_pkg;

    localparam int DATA_ADDR_WD = 32;
    localparam int DATA_DATA_WD = 64;
    localparam int DATA_WEN_WD  = DATA_DATA_WD / 8;
    localparam int INST_WD      = 32;

    localparam int ysyx_22041752_ARB_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF_RD = 2'd1,
        OWN_D_RD  = 2'd2,
        OWN_D_WR  = 2'd3
    } owner_t;

    function automatic logic [DATA_ADDR_WD-1:0] word_align(input logic [DATA_ADDR_WD-1:0] addr);
        return {addr[DATA_ADDR_WD-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/ysyx_22041752_arb_starve_cnt.sv
// rtl/ysyx_22041752_arb_starve_cnt.sv - saturating fetch starvation counter
module ysyx_22041752_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       inc,
    output logic       at_max,
    output logic [3:0] cnt
);

    localparam logic [3:0] MAX_C = 4'(MAX_WAIT);

    assign at_max = (cnt == MAX_C);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/ysyx_22041752_mem_arbiter.sv
// rtl/ysyx_22041752_mem_arbiter.sv - fetch/data arbiter onto one single-ported SRAM
module ysyx_22041752_mem_arbiter
    import ysyx_22041752_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WD  = DATA_ADDR_WD,
    parameter int DATA_WD  = DATA_DATA_WD,
    parameter int INST_WD  = ysyx_22041752_mem_arbiter_pkg::INST_WD,
    parameter int MAX_WAIT = ysyx_22041752_ARB_MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 if_req,
    input  logic [ADDR_WD-1:0]   if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [INST_WD-1:0]   if_rdata,
    input  logic                 d_req,
    input  logic [DATA_WD/8-1:0] d_wen,
    input  logic [ADDR_WD-1:0]   d_addr,
    input  logic [DATA_WD-1:0]   d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [DATA_WD-1:0]   d_rdata,
    output logic                 d_wdone,
    output logic                 mem_en,
    output logic [DATA_WD/8-1:0] mem_wen,
    output logic [ADDR_WD-1:0]   mem_addr,
    output logic [DATA_WD-1:0]   mem_wdata,
    input  logic [DATA_WD-1:0]   mem_rdata
);

    owner_t     owner;
    logic       half;
    logic       rst_done;
    logic       at_max;
    logic [3:0] wait_cnt;
    logic       force_if;
    logic       pick_d;
    logic       pick_if;

    // Nothing is granted until the first clean edge after reset release.
    assign force_if = if_req && at_max;
    assign pick_d   = rst_done && d_req && !force_if;
    assign pick_if  = rst_done && if_req && !pick_d;

    ysyx_22041752_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (pick_if || !if_req),
        .inc    (rst_done && if_req && !pick_if),
        .at_max (at_max),
        .cnt    (wait_cnt)
    );

    assign if_gnt    = pick_if;
    assign d_gnt     = pick_d;
    assign mem_en    = pick_if || pick_d;
    assign mem_addr  = pick_d ? {d_addr[ADDR_WD-1:3], 3'b000} : {if_addr[ADDR_WD-1:3], 3'b000};
    assign mem_wen   = pick_d ? d_wen : '0;
    assign mem_wdata = d_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner    <= OWN_NONE;
            half     <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (pick_if) begin
                owner <= OWN_IF_RD;
                half  <= if_addr[2];
            end else if (pick_d) begin
                owner <= (d_wen == '0) ? OWN_D_RD : OWN_D_WR;
            end else begin
                owner <= OWN_NONE;
            end
        end
    end

    // Fixed one-cycle response: owner names who the current mem_rdata belongs to.
    assign if_rvalid = (owner == OWN_IF_RD);
    assign if_rdata  = half ? mem_rdata[2*INST_WD-1:INST_WD] : mem_rdata[INST_WD-1:0];
    assign d_rvalid  = (owner == OWN_D_RD);
    assign d_rdata   = mem_rdata;
    assign d_wdone   = (owner == OWN_D_WR);

    logic unused_bits;
    assign unused_bits = ^{if_addr[1:0], d_addr[2:0], wait_cnt};

endmodule

// File: tb/tb_ysyx_22041752_mem_arbiter.sv
// tb/tb_ysyx_22041752_mem_arbiter.sv - directed self-checking bench for the memory arbiter
module tb_ysyx_22041752_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [7:0]  d_wen;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        d_wdone;
    logic        mem_en;
    logic [7:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    ysyx_22041752_mem_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_wdone   (d_wdone),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Starvation pattern starting right after reset release, MAX_WAIT=4.
    logic exp_ifg [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic exp_ifv [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic exp_dv  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        resetn    = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h8000_0004;
        d_req     = 1'b1;
        d_wen     = 8'h00;
        d_addr    = 32'h8000_0013;
        d_wdata   = 64'h0;
        mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;

        repeat (3) step();
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_d_wdone", d_wdone, 0);

        step();
        resetn = 1'b1;
        #1;
        chk("rel_first_mem_en", mem_en, 0);
        chk("rel_first_d_gnt", d_gnt, 0);

        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            chk($sformatf("starve_if_gnt_%0d", i), if_gnt, exp_ifg[i]);
            chk($sformatf("starve_d_gnt_%0d", i), d_gnt, !exp_ifg[i]);
            chk($sformatf("starve_mem_en_%0d", i), mem_en, 1);
            chk($sformatf("starve_mem_addr_%0d", i), mem_addr,
                exp_ifg[i] ? 32'h8000_0000 : 32'h8000_0010);
            chk($sformatf("starve_if_rvalid_%0d", i), if_rvalid, exp_ifv[i]);
            chk($sformatf("starve_d_rvalid_%0d", i), d_rvalid, exp_dv[i]);
        end

        step();
        if_req = 1'b0;
        d_req  = 1'b0;
        #1;
        chk("tail_if_rvalid", if_rvalid, 1);
        chk("tail_if_rdata_hi", if_rdata, 32'hAAAA_BBBB);
        chk("tail_mem_en", mem_en, 0);

        step();
        #1;
        chk("idle_if_rvalid", if_rvalid, 0);
        chk("idle_d_rvalid", d_rvalid, 0);

        // Lone fetch, upper half.
        step();
        if_req  = 1'b1;
        if_addr = 32'h8000_0004;
        #1;
        chk("fetch_hi_gnt", if_gnt, 1);
        chk("fetch_hi_addr", mem_addr, 32'h8000_0000);
        chk("fetch_hi_wen", mem_wen, 0);
        step();
        if_req = 1'b0;
        #1;
        chk("fetch_hi_rvalid", if_rvalid, 1);
        chk("fetch_hi_rdata", if_rdata, 32'hAAAA_BBBB);

        // Lone fetch, lower half.
        step();
        if_req  = 1'b1;
        if_addr = 32'h8000_0008;
        #1;
        chk("fetch_lo_addr", mem_addr, 32'h8000_0008);
        step();
        if_req = 1'b0;
        #1;
        chk("fetch_lo_rdata", if_rdata, 32'hCCCC_DDDD);

        // Load.
        step();
        d_req  = 1'b1;
        d_wen  = 8'h00;
        d_addr = 32'h8000_0010;
        #1;
        chk("load_gnt", d_gnt, 1);
        chk("load_addr", mem_addr, 32'h8000_0010);
        chk("load_wen", mem_wen, 0);
        step();
        d_req     = 1'b0;
        mem_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("load_rvalid", d_rvalid, 1);
        chk("load_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
        chk("load_if_rvalid", if_rvalid, 0);
        chk("load_wdone", d_wdone, 0);

        // Store with upper strobes.
        step();
        d_req   = 1'b1;
        d_wen   = 8'hF0;
        d_addr  = 32'h8000_001C;
        d_wdata = 64'h1122_3344_5566_7788;
        #1;
        chk("store_gnt", d_gnt, 1);
        chk("store_wen", mem_wen, 8'hF0);
        chk("store_addr", mem_addr, 32'h8000_0018);
        chk("store_wdata", mem_wdata, 64'h1122_3344_5566_7788);
        step();
        d_req = 1'b0;
        d_wen = 8'h00;
        #1;
        chk("store_wdone", d_wdone, 1);
        chk("store_rvalid", d_rvalid, 0);

        // Partial strobe back-to-back with a same-address read.
        step();
        d_req  = 1'b1;
        d_wen  = 8'h0F;
        d_addr = 32'h8000_0018;
        #1;
        chk("pstore_wen", mem_wen, 8'h0F);
        step();
        d_wen     = 8'h00;
        mem_rdata = 64'h1122_3344_5566_7788;
        #1;
        chk("pstore_wdone", d_wdone, 1);
        chk("raw_read_gnt", d_gnt, 1);
        chk("raw_read_wen", mem_wen, 0);
        step();
        d_req = 1'b0;
        #1;
        chk("raw_read_rvalid", d_rvalid, 1);
        chk("raw_read_rdata", d_rdata, 64'h1122_3344_5566_7788);

        // Back-to-back fetch then load.
        step();
        if_req  = 1'b1;
        if_addr = 32'h8000_0020;
        #1;
        chk("b2b_if_gnt", if_gnt, 1);
        chk("b2b_mem_en0", mem_en, 1);
        step();
        if_req    = 1'b0;
        d_req     = 1'b1;
        d_wen     = 8'h00;
        d_addr    = 32'h8000_0028;
        mem_rdata = 64'h5555_6666_7777_8888;
        #1;
        chk("b2b_if_rvalid", if_rvalid, 1);
        chk("b2b_if_rdata", if_rdata, 32'h7777_8888);
        chk("b2b_d_gnt", d_gnt, 1);
        chk("b2b_mem_en1", mem_en, 1);
        chk("b2b_mem_addr1", mem_addr, 32'h8000_0028);
        step();
        d_req     = 1'b0;
        mem_rdata = 64'h9999_AAAA_BBBB_CCCC;
        #1;
        chk("b2b_d_rvalid", d_rvalid, 1);
        chk("b2b_d_rdata", d_rdata, 64'h9999_AAAA_BBBB_CCCC);
        chk("b2b_if_rvalid_off", if_rvalid, 0);

        // Reset while a load response is outstanding.
        step();
        d_req  = 1'b1;
        d_addr = 32'h8000_0030;
        #1;
        chk("rstmid_gnt", d_gnt, 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("rstmid_d_rvalid", d_rvalid, 0);
        chk("rstmid_mem_en", mem_en, 0);
        step();
        #1;
        chk("rstmid_d_rvalid_later", d_rvalid, 0);
        chk("rstmid_d_gnt", d_gnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
